// File: rtl/ahb_apb_pkg.sv
// ============================================================================
// ahb_apb_pkg : shared types, bus encodings and strobe helper for the bridge
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package ahb_apb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_ACCESS = 3'd2,
        ST_ERR1   = 3'd3,
        ST_ERR2   = 3'd4
    } state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    // Reads never strobe; illegal sizes are rejected before this is used.
    function automatic logic [3:0] pstrb_gen(input logic [2:0] hsize,
                                             input logic [1:0] addr_lo,
                                             input logic       write);
        logic [3:0] strb;
        strb = 4'b0000;
        if (write) begin
            case (hsize)
                HSIZE_BYTE: strb = 4'b0001 << addr_lo;
                HSIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
                default:    strb = 4'b1111;
            endcase
        end
        return strb;
    endfunction

endpackage

`default_nettype wire

// File: rtl/apb_timeout_cnt.sv
// ============================================================================
// apb_timeout_cnt : counts APB wait states, flags expiry at TIMEOUT
// Revision        : 1.0  initial release
// ============================================================================
`default_nettype none

module apb_timeout_cnt #(
    parameter int TIMEOUT = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != LIMIT)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires in the wait cycle whose increment would reach the limit.
    assign expired = en && !clr && (cnt_d == LIMIT);

endmodule

`default_nettype wire

// File: rtl/ahb_apb4_bridge.sv
// ============================================================================
// ahb_apb4_bridge : AHB-Lite slave to APB4 master with slot decode and timeout
// Revision        : 1.0  initial release
// ============================================================================
`default_nettype none

module ahb_apb4_bridge #(
    parameter int NUM_SLOTS = 16,
    parameter int SEL_LSB   = 24,
    parameter int PADDR_W   = 32,
    parameter int TIMEOUT   = 256
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    input  logic                 HSEL,
    input  logic [31:0]          HADDR,
    input  logic                 HWRITE,
    input  logic [1:0]           HTRANS,
    input  logic [2:0]           HSIZE,
    input  logic [3:0]           HPROT,
    input  logic [31:0]          HWDATA,
    input  logic                 HREADYIN,
    output logic                 HREADYOUT,
    output logic                 HRESP,
    output logic [31:0]          HRDATA,
    output logic [NUM_SLOTS-1:0] PSEL,
    output logic [PADDR_W-1:0]   PADDR,
    output logic                 PWRITE,
    output logic                 PENABLE,
    output logic [31:0]          PWDATA,
    output logic [3:0]           PSTRB,
    output logic [2:0]           PPROT,
    input  logic [31:0]          PRDATA,
    input  logic                 PREADY,
    input  logic                 PSLVERR
);

    import ahb_apb_pkg::*;

    state_e               state_q,   state_d;
    logic [NUM_SLOTS-1:0] psel_q,    psel_d;
    logic                 penable_q, penable_d;
    logic                 pwrite_q,  pwrite_d;
    logic [PADDR_W-1:0]   paddr_q,   paddr_d;
    logic [31:0]          pwdata_q,  pwdata_d;
    logic [3:0]           pstrb_q,   pstrb_d;
    logic [2:0]           pprot_q,   pprot_d;

    logic [3:0] slot;
    logic       slot_bad;
    logic       size_bad;
    logic       req;
    logic       done;
    logic       accept;
    logic       tmo_clr;
    logic       tmo_en;
    logic       tmo_expired;

    assign slot     = HADDR[SEL_LSB +: 4];
    assign slot_bad = ({1'b0, slot} >= 5'(NUM_SLOTS));
    assign size_bad = (HSIZE > HSIZE_WORD);
    assign req      = HSEL & HREADYIN & HTRANS[1];
    assign done     = (state_q == ST_ACCESS) & PREADY & ~PSLVERR;
    assign accept   = req & ((state_q == ST_IDLE) | done);
    assign tmo_en   = (state_q == ST_ACCESS) & ~PREADY;

    always_comb begin
        state_d   = state_q;
        psel_d    = psel_q;
        penable_d = penable_q;
        pwrite_d  = pwrite_q;
        paddr_d   = paddr_q;
        pwdata_d  = pwdata_q;
        pstrb_d   = pstrb_q;
        pprot_d   = pprot_q;
        tmo_clr   = 1'b0;

        case (state_q)
            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
                pwdata_d  = HWDATA;
            end
            ST_ACCESS: begin
                // PREADY is checked first so it wins over a coincident expiry.
                if (PREADY) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    state_d   = PSLVERR ? ST_ERR1 : ST_IDLE;
                end else if (tmo_expired) begin
                    psel_d    = '0;
                    penable_d = 1'b0;
                    state_d   = ST_ERR1;
                end
            end
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = ST_IDLE;
            default: state_d = state_q;
        endcase

        if (accept) begin
            if (slot_bad || size_bad) begin
                state_d = ST_ERR1;
            end else begin
                state_d  = ST_SETUP;
                psel_d   = NUM_SLOTS'(1) << slot;
                paddr_d  = HADDR[PADDR_W-1:0];
                pwrite_d = HWRITE;
                pstrb_d  = pstrb_gen(HSIZE, HADDR[1:0], HWRITE);
                pprot_d  = {~HPROT[0], 1'b1, HPROT[1]};
                tmo_clr  = 1'b1;
            end
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q   <= ST_IDLE;
            psel_q    <= '0;
            penable_q <= 1'b0;
            pwrite_q  <= 1'b0;
            paddr_q   <= '0;
            pwdata_q  <= '0;
            pstrb_q   <= '0;
            pprot_q   <= '0;
        end else begin
            state_q   <= state_d;
            psel_q    <= psel_d;
            penable_q <= penable_d;
            pwrite_q  <= pwrite_d;
            paddr_q   <= paddr_d;
            pwdata_q  <= pwdata_d;
            pstrb_q   <= pstrb_d;
            pprot_q   <= pprot_d;
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_timeout
            apb_timeout_cnt #(
                .TIMEOUT (TIMEOUT)
            ) u_timeout_cnt (
                .clk     (HCLK),
                .rst     (HRESET),
                .clr     (tmo_clr),
                .en      (tmo_en),
                .expired (tmo_expired)
            );
        end else begin : g_no_timeout
            assign tmo_expired = 1'b0;
        end
    endgenerate

    assign HREADYOUT = (state_q == ST_IDLE) | (state_q == ST_ERR2) | done;
    assign HRESP     = ((state_q == ST_ERR1) | (state_q == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
    assign HRDATA    = PRDATA;
    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PSTRB     = pstrb_q;
    assign PPROT     = pprot_q;
    // Write data is not yet registered during SETUP, so pass it straight through.
    assign PWDATA    = (state_q == ST_SETUP) ? HWDATA : pwdata_q;

    logic unused_ok;
    assign unused_ok = ^{HTRANS[0], HPROT[3:2], HADDR, tmo_clr, tmo_en};

endmodule

`default_nettype wire

// File: tb/tb_ahb_apb4_bridge.sv
// ============================================================================
// tb_ahb_apb4_bridge : directed self-checking bench (4 slots, timeout of 8)
// Revision           : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ahb_apb4_bridge;

    localparam int NS = 4;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        hsel;
    logic [31:0] haddr;
    logic        hwrite;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [3:0]  hprot;
    logic [31:0] hwdata;
    logic        hreadyin;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic [NS-1:0] psel;
    logic [31:0] paddr;
    logic        pwrite;
    logic        penable;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
    logic [2:0]  pprot;
    logic [31:0] prdata;
    logic        pready;
    logic        pslverr;

    int n_cmp = 0;
    int n_err = 0;
    int low_cnt;

    always #5 clk = ~clk;

    assign hreadyin = hreadyout;

    ahb_apb4_bridge #(
        .NUM_SLOTS (NS),
        .SEL_LSB   (24),
        .PADDR_W   (32),
        .TIMEOUT   (TO)
    ) u_dut (
        .HCLK      (clk),
        .HRESET    (rst),
        .HSEL      (hsel),
        .HADDR     (haddr),
        .HWRITE    (hwrite),
        .HTRANS    (htrans),
        .HSIZE     (hsize),
        .HPROT     (hprot),
        .HWDATA    (hwdata),
        .HREADYIN  (hreadyin),
        .HREADYOUT (hreadyout),
        .HRESP     (hresp),
        .HRDATA    (hrdata),
        .PSEL      (psel),
        .PADDR     (paddr),
        .PWRITE    (pwrite),
        .PENABLE   (penable),
        .PWDATA    (pwdata),
        .PSTRB     (pstrb),
        .PPROT     (pprot),
        .PRDATA    (prdata),
        .PREADY    (pready),
        .PSLVERR   (pslverr)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drive_addr(input logic [31:0] a, input logic w, input logic [2:0] s,
                              input logic [3:0] p);
        hsel   = 1'b1;
        htrans = 2'b10;
        haddr  = a;
        hwrite = w;
        hsize  = s;
        hprot  = p;
    endtask

    task automatic drive_idle();
        hsel   = 1'b0;
        htrans = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        drive_idle();
        haddr = '0; hwrite = 1'b0; hsize = 3'd0; hprot = 4'd0;
        hwdata = '0; prdata = '0; pready = 1'b1; pslverr = 1'b0;

        // ---------------- reset state
        next_cycle(); next_cycle(); settle();
        check_eq("rst_hreadyout", hreadyout, 1);
        check_eq("rst_hresp",     hresp, 0);
        check_eq("rst_psel",      psel, 0);
        check_eq("rst_penable",   penable, 0);
        check_eq("rst_paddr",     paddr, 0);
        check_eq("rst_pstrb_pprot", {pstrb, pprot}, 0);
        check_eq("rst_pwdata",    pwdata, 0);

        // ---------------- word write to slot 3
        next_cycle(); rst = 1'b0;
        drive_addr(32'h0300_0010, 1'b1, 3'd2, 4'b0011); settle();
        check_eq("t1_idle_ready", hreadyout, 1);
        next_cycle(); drive_idle(); hwdata = 32'hDEAD_BEEF; settle();
        check_eq("t1_setup_psel",    psel, 4'h8);
        check_eq("t1_setup_penable", penable, 0);
        check_eq("t1_setup_paddr",   paddr, 32'h0300_0010);
        check_eq("t1_setup_pwdata",  pwdata, 32'hDEAD_BEEF);
        check_eq("t1_setup_pstrb",   pstrb, 4'hF);
        check_eq("t1_setup_pprot",   pprot, 3'b011);
        check_eq("t1_setup_pwrite",  pwrite, 1);
        check_eq("t1_setup_hready",  hreadyout, 0);
        next_cycle(); hwdata = 32'h0; settle();
        check_eq("t1_access_psel",    psel, 4'h8);
        check_eq("t1_access_penable", penable, 1);
        check_eq("t1_access_hready",  hreadyout, 1);
        check_eq("t1_access_hresp",   hresp, 0);
        check_eq("t1_access_pwdata",  pwdata, 32'hDEAD_BEEF);
        next_cycle(); settle();
        check_eq("t1_idle_psel_pen", {psel, penable}, 0);

        // ---------------- byte then halfword write, two wait states each
        drive_addr(32'h0100_0002, 1'b1, 3'd0, 4'b0001); settle();
        next_cycle(); drive_idle(); hwdata = 32'h00AA_0000; pready = 1'b0; settle();
        low_cnt = (hreadyout == 1'b0) ? 1 : 0;
        check_eq("t2a_setup_psel",  psel, 4'h2);
        check_eq("t2a_setup_pstrb", pstrb, 4'b0100);
        for (int i = 0; i < 2; i++) begin
            next_cycle(); settle();
            if (hreadyout == 1'b0) low_cnt++;
            check_eq("t2a_wait_pen_rdy", {penable, hreadyout}, 2'b10);
        end
        next_cycle(); pready = 1'b1; drive_addr(32'h0100_0002, 1'b1, 3'd1, 4'b0001); settle();
        check_eq("t2a_done_hready", hreadyout, 1);
        check_eq("t2a_low_cycles", low_cnt, 3);
        next_cycle(); drive_idle(); hwdata = 32'hBBBB_0000; pready = 1'b0; settle();
        low_cnt = (hreadyout == 1'b0) ? 1 : 0;
        check_eq("t2b_setup_psel_pen", {psel, penable}, {4'h2, 1'b0});
        check_eq("t2b_setup_pstrb",    pstrb, 4'b1100);
        check_eq("t2b_setup_pwdata",   pwdata, 32'hBBBB_0000);
        for (int i = 0; i < 2; i++) begin
            next_cycle(); settle();
            if (hreadyout == 1'b0) low_cnt++;
        end
        next_cycle(); pready = 1'b1; settle();
        check_eq("t2b_done_hready", hreadyout, 1);
        check_eq("t2b_low_cycles", low_cnt, 3);
        next_cycle(); settle();
        check_eq("t2b_idle_psel", psel, 0);

        // ---------------- read from slot 0 with PSLVERR
        drive_addr(32'h0000_0040, 1'b0, 3'd2, 4'b0000); settle();
        next_cycle(); drive_idle(); settle();
        check_eq("t3_setup_psel",  psel, 4'h1);
        check_eq("t3_setup_pstrb", {pwrite, pstrb}, 0);
        check_eq("t3_setup_pprot", pprot, 3'b110);
        next_cycle(); pready = 1'b1; pslverr = 1'b1; prdata = 32'h1234_5678; settle();
        check_eq("t3_access_hready", hreadyout, 0);
        check_eq("t3_access_hrdata", hrdata, 32'h1234_5678);
        next_cycle(); pslverr = 1'b0; settle();
        check_eq("t3_err1", {psel, penable, hreadyout, hresp}, 7'b0000_0_0_1);
        next_cycle(); settle();
        check_eq("t3_err2", {hreadyout, hresp}, 2'b11);
        next_cycle(); settle();
        check_eq("t3_idle_hresp", hresp, 0);

        // ---------------- unmapped slot 9, then illegal size
        drive_addr(32'h0900_0000, 1'b1, 3'd2, 4'b0000); settle();
        next_cycle(); drive_idle(); settle();
        check_eq("t4a_err1", {psel, hreadyout, hresp}, 6'b0000_0_1);
        check_eq("t4a_paddr_kept", paddr, 32'h0000_0040);
        next_cycle(); settle();
        check_eq("t4a_err2", {psel, hreadyout, hresp}, 6'b0000_1_1);
        next_cycle(); drive_addr(32'h0100_0000, 1'b1, 3'd3, 4'b0000); settle();
        next_cycle(); drive_idle(); settle();
        check_eq("t4b_err1", {psel, hreadyout, hresp}, 6'b0000_0_1);
        next_cycle(); settle();
        check_eq("t4b_err2", {psel, hreadyout, hresp}, 6'b0000_1_1);
        next_cycle(); settle();

        // ---------------- timeout with PREADY held low
        drive_addr(32'h0200_0000, 1'b1, 3'd2, 4'b0000); settle();
        next_cycle(); drive_idle(); pready = 1'b0; settle();
        check_eq("t5a_setup_psel", psel, 4'h4);
        for (int i = 1; i <= TO; i++) begin
            next_cycle(); settle();
            check_eq("t5a_access", {psel, penable, hreadyout}, {4'h4, 1'b1, 1'b0});
        end
        next_cycle(); settle();
        check_eq("t5a_err1", {psel, penable, hreadyout, hresp}, 7'b0000_0_0_1);
        next_cycle(); settle();
        check_eq("t5a_err2", {hreadyout, hresp}, 2'b11);
        next_cycle(); settle();

        // ---------------- PREADY rises on the last allowed cycle
        drive_addr(32'h0200_0004, 1'b1, 3'd2, 4'b0000); settle();
        next_cycle(); drive_idle(); pready = 1'b0; settle();
        for (int i = 1; i < TO; i++) begin
            next_cycle(); settle();
        end
        next_cycle(); pready = 1'b1; settle();
        check_eq("t5b_done", {penable, hreadyout, hresp}, 3'b110);
        next_cycle(); settle();
        check_eq("t5b_idle", {psel, hresp}, 0);

        // ---------------- asynchronous reset mid-ACCESS
        drive_addr(32'h0100_0004, 1'b1, 3'd2, 4'b0011); settle();
        next_cycle(); drive_idle(); hwdata = 32'h5555_AAAA; pready = 1'b0; settle();
        next_cycle(); settle();
        check_eq("t6_access_penable", penable, 1);
        #2; rst = 1'b1; #1;
        check_eq("t6_rst_psel_pen",   {psel, penable}, 0);
        check_eq("t6_rst_paddr",      paddr, 0);
        check_eq("t6_rst_strb_prot",  {pstrb, pprot, pwrite}, 0);
        check_eq("t6_rst_pwdata",     pwdata, 0);
        check_eq("t6_rst_hready",     {hreadyout, hresp}, 2'b10);
        next_cycle(); rst = 1'b0; pready = 1'b1; prdata = 32'hCAFE_F00D;
        drive_addr(32'h0300_0008, 1'b0, 3'd2, 4'b0000); settle();
        check_eq("t6_idle_hready", hreadyout, 1);
        next_cycle(); drive_idle(); settle();
        check_eq("t6_setup", {psel, penable}, {4'h8, 1'b0});
        check_eq("t6_setup_paddr", paddr, 32'h0300_0008);
        next_cycle(); settle();
        check_eq("t6_access", {penable, hreadyout, hresp}, 3'b110);
        check_eq("t6_hrdata", hrdata, 32'hCAFE_F00D);
        next_cycle(); settle();
        check_eq("t6_idle", psel, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
